// File: rtl/mode_sched_pkg.sv
// Shared definitions for the piano mode controller and its players:
// mode and note encodings, the FSM state type and conversion helpers.
package mode_sched_pkg;

  localparam int unsigned CLK_HZ = 70000000;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_AUTO  = 2'b10;
  localparam logic [1:0] MODE_LEARN = 2'b11;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FREE,
    ST_AUTO,
    ST_LEARN,
    ST_SWITCH
  } state_t;

  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_FREE:  return ST_FREE;
      MODE_AUTO:  return ST_AUTO;
      MODE_LEARN: return ST_LEARN;
      default:    return ST_IDLE;
    endcase
  endfunction

  // SWITCH reports idle: no mode is effective while the gap runs.
  function automatic logic [1:0] state_to_mode(input state_t st);
    case (st)
      ST_FREE:  return MODE_FREE;
      ST_AUTO:  return MODE_AUTO;
      ST_LEARN: return MODE_LEARN;
      default:  return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mode_sched_gap_timer.sv
// Silent-gap counter: load clears it, count advances it, done flags the
// last gap cycle.
module mode_sched_gap_timer #(
  parameter int unsigned GAP_CYCLES = 7000000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      gap_cnt <= '0;
    end else if (count) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign done = (gap_cnt == LAST);

endmodule

// File: rtl/mode_sched.sv
// Piano mode scheduler: grants one player at a time, inserts a silent,
// player-clearing gap on every mode change and drives buzzer/LEDs.
module mode_sched
  import mode_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 7000000,
  parameter int unsigned CNT_W      = 24,
  parameter bit          AUTO_LOOP  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_sel,
  input  logic       mode_confirm,
  input  logic [3:0] free_note,
  input  logic [6:0] free_led,
  input  logic [3:0] auto_note,
  input  logic [6:0] auto_led,
  input  logic       auto_done,
  input  logic [3:0] learn_note,
  input  logic [6:0] learn_led,
  output logic       free_en,
  output logic       auto_en,
  output logic       learn_en,
  output logic       sub_rst,
  output logic [1:0] mode_cur,
  output logic       busy,
  output logic [3:0] buzz_note,
  output logic [6:0] led_out,
  output state_t     state_dbg
);

  // mode_confirm and auto_done are single-cycle pulses accepted on the
  // edge they are high; there is no back-pressure to the front end.
  state_t     state, state_n;
  logic [1:0] target, target_n;
  logic       gap_load, gap_count, gap_done;
  logic       clr_pulse, init_pend;
  logic [3:0] src_note, mux_note;
  logic [6:0] src_led, mux_led;

  mode_sched_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W     (CNT_W)
  ) u_gap (
    .clk  (clk),
    .rst  (rst),
    .load (gap_load),
    .count(gap_count),
    .done (gap_done)
  );

  always_comb begin
    state_n   = state;
    target_n  = target;
    gap_load  = 1'b0;
    clr_pulse = 1'b0;
    if (state == ST_SWITCH) begin
      if (mode_confirm) begin
        target_n  = mode_sel;
        gap_load  = 1'b1;
        clr_pulse = 1'b1;
      end else if (gap_done) begin
        state_n = mode_to_state(target);
      end
    end else if (mode_confirm && (mode_sel != state_to_mode(state))) begin
      state_n   = ST_SWITCH;
      target_n  = mode_sel;
      gap_load  = 1'b1;
      clr_pulse = 1'b1;
    end else if ((state == ST_AUTO) && auto_done) begin
      clr_pulse = 1'b1;
      if (!AUTO_LOOP) begin
        state_n  = ST_SWITCH;
        target_n = MODE_IDLE;
        gap_load = 1'b1;
      end
    end
  end

  assign gap_count = (state == ST_SWITCH) && !gap_load;

  // Output mux follows the current grant, silenced as soon as a gap begins.
  always_comb begin
    src_note = NOTE_REST;
    src_led  = '0;
    case (state)
      ST_FREE:  begin src_note = free_note;  src_led = free_led;  end
      ST_AUTO:  begin src_note = auto_note;  src_led = auto_led;  end
      ST_LEARN: begin src_note = learn_note; src_led = learn_led; end
      default:  begin src_note = NOTE_REST;  src_led = '0;        end
    endcase
    if ((state_n == ST_SWITCH) || (src_note > NOTE_SI)) begin
      mux_note = NOTE_REST;
      mux_led  = '0;
    end else begin
      mux_note = src_note;
      mux_led  = src_led;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= MODE_IDLE;
      init_pend <= 1'b1;
      free_en   <= 1'b0;
      auto_en   <= 1'b0;
      learn_en  <= 1'b0;
      sub_rst   <= 1'b0;
      mode_cur  <= MODE_IDLE;
      busy      <= 1'b0;
      buzz_note <= NOTE_REST;
      led_out   <= '0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      init_pend <= 1'b0;
      free_en   <= (state_n == ST_FREE);
      auto_en   <= (state_n == ST_AUTO);
      learn_en  <= (state_n == ST_LEARN);
      sub_rst   <= clr_pulse || init_pend;
      mode_cur  <= state_to_mode(state_n);
      busy      <= (state_n == ST_SWITCH);
      buzz_note <= mux_note;
      led_out   <= mux_led;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mode_sched.sv
// Bench for mode_sched: two instances (AUTO_LOOP 0 and 1) on shared stimulus,
// each checked cycle by cycle against a gap/grant reference model.
module tb_mode_sched;
  import mode_sched_pkg::*;

  localparam int G = 4;
  localparam int W = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_sel = 2'b00;
  logic       mode_confirm = 1'b0;
  logic [3:0] free_note = 4'd0, auto_note = 4'd0, learn_note = 4'd0;
  logic [6:0] free_led = 7'd0, auto_led = 7'd0, learn_led = 7'd0;
  logic       auto_done = 1'b0;

  logic       fe0, ae0, le0, sr0, bz0, fe1, ae1, le1, sr1, bz1;
  logic [1:0] mc0, mc1;
  logic [3:0] bn0, bn1;
  logic [6:0] lo0, lo1;
  state_t     st0, st1;
  logic [W-1:0] act0, act1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always #5 clk = ~clk;

  mode_sched #(.GAP_CYCLES(G), .CNT_W(4), .AUTO_LOOP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .mode_confirm(mode_confirm),
    .free_note(free_note), .free_led(free_led), .auto_note(auto_note),
    .auto_led(auto_led), .auto_done(auto_done), .learn_note(learn_note),
    .learn_led(learn_led), .free_en(fe0), .auto_en(ae0), .learn_en(le0),
    .sub_rst(sr0), .mode_cur(mc0), .busy(bz0), .buzz_note(bn0),
    .led_out(lo0), .state_dbg(st0)
  );

  mode_sched #(.GAP_CYCLES(G), .CNT_W(4), .AUTO_LOOP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .mode_confirm(mode_confirm),
    .free_note(free_note), .free_led(free_led), .auto_note(auto_note),
    .auto_led(auto_led), .auto_done(auto_done), .learn_note(learn_note),
    .learn_led(learn_led), .free_en(fe1), .auto_en(ae1), .learn_en(le1),
    .sub_rst(sr1), .mode_cur(mc1), .busy(bz1), .buzz_note(bn1),
    .led_out(lo1), .state_dbg(st1)
  );

  assign act0 = {fe0, ae0, le0, sr0, mc0, bz0, bn0, lo0};
  assign act1 = {fe1, ae1, le1, sr1, mc1, bz1, bn1, lo1};

  // Reference model: effective mode, whether a gap is running, how many
  // silent cycles are left, where the gap lands, and the post-reset clear.
  typedef struct {
    bit         gapping;
    int         gap_left;
    logic [1:0] mode;
    logic [1:0] tgt;
    bit         init;
  } model_t;

  model_t m0, m1;

  task automatic start_gap(inout model_t m, input logic [1:0] tgt);
    m.gapping  = 1'b1;
    m.gap_left = G;
    m.tgt      = tgt;
    m.mode     = 2'b00;
  endtask

  task automatic step(inout model_t m, input bit loop, output logic [W-1:0] o);
    bit         clr, was_gap;
    logic [1:0] old_mode;
    logic [3:0] n;
    logic [6:0] l;
    if (rst) begin
      m.gapping = 1'b0; m.gap_left = 0; m.mode = 2'b00; m.tgt = 2'b00;
      m.init = 1'b1;
      o = '0;
    end else begin
      clr = m.init;
      m.init = 1'b0;
      was_gap = m.gapping;
      old_mode = m.mode;
      if (m.gapping) begin
        if (mode_confirm) begin
          m.tgt = mode_sel; m.gap_left = G; clr = 1'b1;
        end else begin
          m.gap_left = m.gap_left - 1;
          if (m.gap_left == 0) begin
            m.gapping = 1'b0;
            m.mode = m.tgt;
          end
        end
      end else if (mode_confirm && mode_sel != m.mode) begin
        start_gap(m, mode_sel);
        clr = 1'b1;
      end else if (m.mode == 2'b10 && auto_done) begin
        clr = 1'b1;
        if (!loop) start_gap(m, 2'b00);
      end
      n = 4'd0; l = 7'd0;
      if (!was_gap && !m.gapping) begin
        if (old_mode == 2'b01) begin n = free_note;  l = free_led;  end
        if (old_mode == 2'b10) begin n = auto_note;  l = auto_led;  end
        if (old_mode == 2'b11) begin n = learn_note; l = learn_led; end
        if (n > 4'd7) begin n = 4'd0; l = 7'd0; end
      end
      o = {!m.gapping && m.mode == 2'b01, !m.gapping && m.mode == 2'b10,
           !m.gapping && m.mode == 2'b11, clr, m.mode, m.gapping, n, l};
    end
  endtask

  // Driver: model sees the same inputs the DUT samples on the next edge.
  task automatic cycle();
    logic [W-1:0] o0, o1;
    step(m0, 1'b0, o0);
    step(m1, 1'b1, o1);
    @(posedge clk);
    exp_q0.push_back(o0);
    exp_q1.push_back(o1);
    #1;
    mode_confirm = 1'b0;
    auto_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic confirm(input logic [1:0] sel);
    mode_sel = sel;
    mode_confirm = 1'b1;
    cycle();
  endtask

  // Monitor: compares every registered output word against the scoreboard.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      checks++;
      if (act0 !== e) begin
        errors++;
        $display("FAIL out_loop0 t=%0t: got %h expected %h", $time, act0, e);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      checks++;
      if (act1 !== e) begin
        errors++;
        $display("FAIL out_loop1 t=%0t: got %h expected %h", $time, act1, e);
      end
    end
    checks++;
    if ($countones({fe0, ae0, le0}) > 1 || $countones({fe1, ae1, le1}) > 1) begin
      errors++;
      $display("FAIL en_onehot t=%0t: got %b/%b expected at most one", $time,
               {fe0, ae0, le0}, {fe1, ae1, le1});
    end
  end

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);

    learn_note = 4'd3;
    learn_led = 7'b0000100;
    confirm(2'b11);
    idle(7);

    confirm(2'b11);
    idle(2);
    confirm(2'b10);
    idle(2);
    confirm(2'b01);
    idle(6);

    auto_note = 4'd5;
    auto_led = 7'b0010000;
    confirm(2'b10);
    idle(6);
    auto_done = 1'b1;
    cycle();
    idle(6);
    confirm(2'b10);
    idle(6);

    free_note = 4'd9;
    free_led = 7'b1111111;
    mode_sel = 2'b01;
    mode_confirm = 1'b1;
    auto_done = 1'b1;
    cycle();
    idle(8);
    free_note = 4'd6;
    free_led = 7'b0100000;
    idle(2);

    confirm(2'b10);
    idle(2);
    rst = 1'b1;
    cycle();
    checks++;
    if (st0 !== ST_IDLE || st1 !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_gap: got state %0d/%0d expected %0d", st0, st1, ST_IDLE);
    end
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      mode_sel     = 2'($urandom_range(0, 3));
      mode_confirm = ($urandom_range(0, 11) == 0);
      auto_done    = ($urandom_range(0, 9) == 0);
      free_note    = 4'($urandom_range(0, 15));
      auto_note    = 4'($urandom_range(0, 15));
      learn_note   = 4'($urandom_range(0, 15));
      free_led     = 7'($urandom);
      auto_led     = 7'($urandom);
      learn_led    = 7'($urandom);
      rst          = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
